fifo_write_arbiter: RTL and testbench
=====================================

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 The block SHALL have parameter DSIZE, default 16, meaning FIFO word width in bits.
REQ-002 The block SHALL have parameter NREQ, default 4, meaning the number of requesters (2..8).
REQ-003 The block SHALL have parameter MAX_BURST, default 8, meaning the maximum words per grant (1..255).
REQ-004 wclk  input  1  write-domain clock; all state changes on its rising edge.
REQ-005 wrst_n  input  1  reset, synchronous, active-low.
REQ-006 req_i  input  NREQ  per-requester "word available" level.
REQ-007 wdata_i  input  NREQ*DSIZE  requester i word at bits [i*DSIZE +: DSIZE].
REQ-008 ack_o  output  NREQ  one-hot; ack_o[i]=1 means requester i's word is consumed this cycle.
REQ-009 wfull_i  input  1  FIFO almost-full back-pressure, tied to the FIFO walmostfull/wfull.
REQ-010 winc_o  output  1  registered FIFO write strobe.
REQ-011 wdata_o  output  DSIZE  registered FIFO write data.
REQ-012 owner_o  output  NREQ  one-hot current grant; all-zero when idle.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-014 In IDLE with any req_i set, the FSM SHALL grant the first requester with req_i set, searching from (last_owner+1) mod NREQ, and enter GRANT next cycle.
REQ-015 In IDLE, ack_o SHALL be zero.
REQ-016 In GRANT, ack_o[owner] SHALL equal req_i[owner] && !wfull_i (combinational); all other ack_o bits SHALL be zero.
REQ-017 On an acked cycle, wdata_o SHALL load that requester's word and winc_o SHALL be 1 the next cycle (one-cycle latency).
REQ-018 On cycles with no ack, winc_o SHALL be 0 the next cycle and wdata_o SHALL hold its value.
REQ-019 An 8-bit burst counter SHALL clear on entry to GRANT and increment on each ack.
REQ-020 GRANT SHALL return to IDLE when req_i[owner] is 0, or when an ack occurs with the counter equal to MAX_BURST-1.
REQ-021 While wfull_i is high in GRANT, the FSM SHALL remain in GRANT with no ack, provided req_i[owner] stays set.
REQ-022 last_owner SHALL update to the owner on every GRANT->IDLE transition.
REQ-023 Req_i changes of non-owners SHALL have no effect during GRANT.
REQ-024 Words SHALL be written in ack order, with no drops or duplicates.

Reset
REQ-025 When wrst_n is 0 at a clock edge, the block SHALL set state IDLE, owner_o 0, last_owner NREQ-1 (so requester 0 has first priority), counter 0, winc_o 0 and wdata_o 0.
REQ-026 A reset asserted mid-burst SHALL abort the burst with no further winc_o.
REQ-027 A word acked in the cycle reset is sampled SHALL NOT be written.

Structure
REQ-028 A shared package fifo_arb_pkg SHALL hold the state enum (IDLE, GRANT) and the burst-counter width constant (8).
REQ-029 One sub-module SHALL exist: rr_pick, a combinational NREQ-wide rotate-priority picker (inputs req and last index; output one-hot grant).
REQ-030 The block SHALL contain no clock-domain crossing logic; the downstream FIFO performs the crossing.

Verification
REQ-031 The bench SHALL cover single requester: req_i=0001, 3 words A,B,C then drop -> winc_o pulses 3 cycles carrying A,B,C, starting one cycle after the first ack, then IDLE.
REQ-032 The bench SHALL cover round-robin: req_i=1111 held, MAX_BURST=2 -> owner_o sequence 0001,0010,0100,1000,0001, two words each, one IDLE cycle between grants.
REQ-033 The bench SHALL cover back-pressure: wfull_i=1 for 5 cycles mid-burst -> zero acks, winc_o=0 for those cycles, grant retained, burst resumes with no word lost.
REQ-034 The bench SHALL cover burst limit: MAX_BURST=8, requester 2 continuous with requester 3 waiting -> exactly 8 acks to 2, then grant moves to 3.
REQ-035 The bench SHALL cover reset mid-burst: wrst_n=0 during 4th word -> next cycle winc_o=0, owner_o=0; after release requester 0 has priority.
REQ-036 The bench SHALL cover end-to-end: the arbiter drives aFifo with DSIZE=16 and 1000 random words; read-side order SHALL match the ack log, with wfull_i tied to walmostfull and no overflow.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM state encoding and
// burst counter width.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int CNT_W = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: returns a one-hot grant for the first
// set request found after index i_last, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [NREQ-1:0]  o_grant
);

  logic             w_found;
  logic [IDX_W-1:0] w_idx;

  // scan from i_last+1 around the ring, first hit wins
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    o_grant = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = IDX_W'((int'(i_last) + k) % NREQ);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that merges NREQ word sources into a single FIFO write
// port, with bounded bursts and almost-full back-pressure.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DSIZE     = 16,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*DSIZE-1:0] wdata_i,
  output logic [NREQ-1:0]       ack_o,
  input  logic                  wfull_i,
  output logic                  winc_o,
  output logic [DSIZE-1:0]      wdata_o,
  output logic [NREQ-1:0]       owner_o
);

  localparam int IDX_W = $clog2(NREQ);

  state_t           r_state;
  state_t           w_next_state;
  logic [NREQ-1:0]  r_owner;
  logic [IDX_W-1:0] r_last;
  logic [CNT_W-1:0] r_cnt;
  logic             r_winc;
  logic [DSIZE-1:0] r_wdata;

  logic [NREQ-1:0]  w_pick;
  logic [NREQ-1:0]  w_ack;
  logic [IDX_W-1:0] w_owner_idx;
  logic             w_owner_req;
  logic             w_burst_end;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req   (req_i),
    .i_last  (r_last),
    .o_grant (w_pick)
  );

  // one-hot owner to binary index
  always_comb begin
    w_owner_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_owner[i]) begin
        w_owner_idx = IDX_W'(i);
      end else begin
        w_owner_idx = w_owner_idx;
      end
    end
  end

  // next state and acknowledge
  always_comb begin
    w_next_state = r_state;
    w_ack        = '0;
    w_owner_req  = |(req_i & r_owner);
    w_burst_end  = (r_cnt == CNT_W'(MAX_BURST - 1));
    case (r_state)
      IDLE: begin
        if (|req_i) begin
          w_next_state = GRANT;
        end else begin
          w_next_state = IDLE;
        end
      end
      GRANT: begin
        if (!wfull_i) begin
          w_ack = req_i & r_owner;
        end else begin
          w_ack = '0;
        end
        if (!w_owner_req) begin
          w_next_state = IDLE;
        end else if ((|w_ack) && w_burst_end) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = GRANT;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_ack        = '0;
      end
    endcase
  end

  // state, grant bookkeeping and registered write port
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_last  <= IDX_W'(NREQ - 1);
      r_cnt   <= '0;
      r_winc  <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next_state;
      r_winc  <= |w_ack;
      if (|w_ack) begin
        r_wdata <= wdata_i[w_owner_idx*DSIZE +: DSIZE];
      end else begin
        r_wdata <= r_wdata;
      end
      case (r_state)
        IDLE: begin
          if (w_next_state == GRANT) begin
            r_owner <= w_pick;
            r_cnt   <= '0;
          end else begin
            r_owner <= r_owner;
          end
        end
        GRANT: begin
          if (w_next_state == IDLE) begin
            r_owner <= '0;
            r_last  <= w_owner_idx;
          end else if (|w_ack) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_cnt <= r_cnt;
          end
        end
        default: begin
          r_owner <= '0;
        end
      endcase
    end
  end

  assign ack_o   = w_ack;
  assign winc_o  = r_winc;
  assign wdata_o = r_wdata;
  assign owner_o = r_owner;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: directed scenarios plus an
// end-to-end run through a behavioural FIFO model with almost-full feedback.
module tb_fifo_write_arbiter;

  localparam int DS    = 16;
  localparam int NR    = 4;
  localparam int DEPTH = 16;
  localparam int AFULL = DEPTH - 2;

  logic wclk = 1'b0;
  always #5 wclk = ~wclk;

  logic              wrst_n;
  logic              wfull;
  logic [NR-1:0]     req;
  logic [DS-1:0]     wd [NR];
  logic [NR*DS-1:0]  wbus;
  assign wbus = {wd[3], wd[2], wd[1], wd[0]};

  logic [NR-1:0] ack2, ack8, own2, own8;
  logic          winc2, winc8;
  logic [DS-1:0] wdo2, wdo8;

  // sel=1 observes the MAX_BURST=8 instance, sel=0 the MAX_BURST=2 one
  logic          sel = 1'b1;
  logic [NR-1:0] ack, owner;
  logic          winc;
  logic [DS-1:0] wdo;
  assign ack   = sel ? ack8  : ack2;
  assign owner = sel ? own8  : own2;
  assign winc  = sel ? winc8 : winc2;
  assign wdo   = sel ? wdo8  : wdo2;

  fifo_write_arbiter #(.DSIZE(DS), .NREQ(NR), .MAX_BURST(2)) u_dut2 (
    .wclk(wclk), .wrst_n(wrst_n), .req_i(req), .wdata_i(wbus), .ack_o(ack2),
    .wfull_i(wfull), .winc_o(winc2), .wdata_o(wdo2), .owner_o(own2)
  );

  fifo_write_arbiter #(.DSIZE(DS), .NREQ(NR), .MAX_BURST(8)) u_dut8 (
    .wclk(wclk), .wrst_n(wrst_n), .req_i(req), .wdata_i(wbus), .ack_o(ack8),
    .wfull_i(wfull), .winc_o(winc8), .wdata_o(wdo8), .owner_o(own8)
  );

  int            n_chk = 0;
  int            n_pass = 0;
  logic          e2e = 1'b0;
  int            max_fill = 0;
  logic [DS-1:0] exp_q [$];
  logic [DS-1:0] log_q [$];
  logic [DS-1:0] fifo_q [$];

  logic [DS-1:0] t1w [3] = '{16'h00A0, 16'h00B0, 16'h00C0};
  logic [DS-1:0] bpw [4] = '{16'hD000, 16'hD001, 16'hD002, 16'hD003};
  logic [NR-1:0] own_tbl [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int            idx_tbl [5] = '{0, 1, 2, 3, 0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset(input logic s);
    sel    = s;
    wrst_n = 1'b0;
    req    = '0;
    wfull  = 1'b0;
    tick();
    tick();
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_winc",  32'(winc),  32'h0);
    chk("rst_wdata", 32'(wdo),   32'h0);
    chk("rst_ack",   32'(ack),   32'h0);
    wrst_n = 1'b1;
  endtask

  task automatic drain_check(input string nm);
    tick();
    tick();
    chk(nm, 32'(exp_q.size()), 32'h0);
  endtask

  // monitor: every write strobe is matched against the expected queue or fed to the FIFO model
  initial begin
    logic [DS-1:0] w;
    forever begin
      @(negedge wclk);
      if (winc === 1'b1) begin
        if (e2e) begin
          fifo_q.push_back(wdo);
          if (fifo_q.size() > max_fill) max_fill = fifo_q.size();
        end else if (exp_q.size() == 0) begin
          chk("unexpected_winc", 32'(wdo), 32'hFFFF_FFFF);
        end else begin
          w = exp_q.pop_front();
          chk("wdata", 32'(wdo), 32'(w));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int            nack;
    int            cyc;
    logic [NR-1:0] acked;
    logic [DS-1:0] r, l;
    for (int i = 0; i < NR; i++) wd[i] = '0;

    // single requester: three words then drop
    do_reset(1'b1);
    req = 4'b0001;
    wd[0] = t1w[0];
    #1 chk("t1_idle_ack", 32'(ack), 32'h0);
    tick();
    chk("t1_owner", 32'(owner), 32'h1);
    for (int i = 0; i < 3; i++) begin
      wd[0] = t1w[i];
      #1 chk("t1_ack", 32'(ack), 32'h1);
      exp_q.push_back(t1w[i]);
      tick();
      chk("t1_winc", 32'(winc), 32'h1);
    end
    req = 4'b0000;
    #1 chk("t1_drop_ack", 32'(ack), 32'h0);
    tick();
    chk("t1_winc_off", 32'(winc), 32'h0);
    chk("t1_idle", 32'(owner), 32'h0);
    drain_check("t1_drain");

    // round robin with MAX_BURST=2
    do_reset(1'b0);
    wd[0] = 16'h1111; wd[1] = 16'h2222; wd[2] = 16'h3333; wd[3] = 16'h4444;
    req = 4'b1111;
    tick();
    for (int g = 0; g < 5; g++) begin
      for (int b = 0; b < 2; b++) begin
        chk("t2_owner", 32'(owner), 32'(own_tbl[g]));
        chk("t2_ack",   32'(ack),   32'(own_tbl[g]));
        exp_q.push_back(wd[idx_tbl[g]]);
        tick();
      end
      chk("t2_gap_owner", 32'(owner), 32'h0);
      chk("t2_gap_ack",   32'(ack),   32'h0);
      tick();
    end
    req = 4'b0000;
    tick();
    drain_check("t2_drain");

    // back-pressure for five cycles mid-burst
    do_reset(1'b1);
    req = 4'b0001;
    wd[0] = bpw[0];
    tick();
    for (int i = 0; i < 2; i++) begin
      wd[0] = bpw[i];
      #1 chk("t3_ack", 32'(ack), 32'h1);
      exp_q.push_back(bpw[i]);
      tick();
    end
    wd[0] = bpw[2];
    wfull = 1'b1;
    for (int f = 0; f < 5; f++) begin
      #1 chk("t3_full_ack", 32'(ack), 32'h0);
      chk("t3_full_owner", 32'(owner), 32'h1);
      tick();
      chk("t3_full_winc", 32'(winc), 32'h0);
    end
    wfull = 1'b0;
    for (int i = 2; i < 4; i++) begin
      wd[0] = bpw[i];
      #1 chk("t3_resume_ack", 32'(ack), 32'h1);
      exp_q.push_back(bpw[i]);
      tick();
    end
    req = 4'b0000;
    tick();
    drain_check("t3_drain");

    // burst limit: requester 2 capped at 8 words, then requester 3
    do_reset(1'b1);
    req = 4'b1100;
    wd[3] = 16'h3333;
    tick();
    for (int i = 0; i < 8; i++) begin
      wd[2] = 16'h2200 + 16'(i);
      #1 chk("t4_owner2", 32'(owner), 32'h4);
      chk("t4_ack2", 32'(ack), 32'h4);
      exp_q.push_back(wd[2]);
      tick();
    end
    chk("t4_released", 32'(owner), 32'h0);
    tick();
    chk("t4_owner3", 32'(owner), 32'h8);
    chk("t4_ack3", 32'(ack), 32'h8);
    exp_q.push_back(wd[3]);
    tick();
    req = 4'b0000;
    tick();
    drain_check("t4_drain");

    // reset during the fourth word of a burst owned by requester 1
    do_reset(1'b1);
    req = 4'b0010;
    tick();
    for (int i = 0; i < 3; i++) begin
      wd[1] = 16'h5500 + 16'(i);
      #1 chk("t5_ack", 32'(ack), 32'h2);
      exp_q.push_back(wd[1]);
      tick();
    end
    wd[1] = 16'h55FF;
    wrst_n = 1'b0;
    tick();
    chk("t5_winc", 32'(winc), 32'h0);
    chk("t5_owner", 32'(owner), 32'h0);
    wrst_n = 1'b1;
    req = 4'b0011;
    tick();
    chk("t5_prio", 32'(owner), 32'h1);
    req = 4'b0000;
    tick();
    drain_check("t5_drain");

    // end to end: 1000 random words through the FIFO model
    do_reset(1'b1);
    e2e = 1'b1;
    nack = 0;
    cyc = 0;
    for (int i = 0; i < NR; i++) wd[i] = 16'($urandom);
    req = 4'b1111;
    while (nack < 1000 && cyc < 20000) begin
      wfull = (fifo_q.size() >= AFULL);
      #1;
      acked = ack;
      for (int i = 0; i < NR; i++) begin
        if (acked[i]) begin
          log_q.push_back(wd[i]);
          nack++;
        end
      end
      if (fifo_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        r = fifo_q.pop_front();
        if (log_q.size() == 0) chk("e2e_log_underflow", 32'h1, 32'h0);
        else begin
          l = log_q.pop_front();
          chk("e2e_order", 32'(r), 32'(l));
        end
      end
      tick();
      cyc++;
      for (int i = 0; i < NR; i++) begin
        if (acked[i]) begin
          wd[i]  = 16'($urandom);
          req[i] = ($urandom_range(0, 3) != 0);
        end else if (!req[i]) begin
          req[i] = ($urandom_range(0, 1) == 1);
        end
      end
    end
    req = 4'b0000;
    wfull = 1'b0;
    tick();
    tick();
    tick();
    while (fifo_q.size() > 0) begin
      r = fifo_q.pop_front();
      if (log_q.size() == 0) chk("e2e_log_underflow", 32'h1, 32'h0);
      else begin
        l = log_q.pop_front();
        chk("e2e_order", 32'(r), 32'(l));
      end
    end
    chk("e2e_acks", 32'(nack >= 1000), 32'h1);
    chk("e2e_log_empty", 32'(log_q.size()), 32'h0);
    chk("e2e_overflow", 32'(max_fill <= DEPTH), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
